// File: rtl/jesd204b_pkg.sv
// JESD204B transport-layer width helpers shared by the TPL and its bench.
package jesd204b_pkg;

   // Converter count padded up to a whole number of converters per lane.
   function automatic int calc_mp(input int m, input int l);
      if (l < 1) begin
         return m;
      end
      if (m % l != 0) begin
         return m + (l - m % l);
      end
      return m;
   endfunction

   // Bits carried by one lane per frame.
   function automatic int calc_lane_width(input int s, input int np, input int m, input int l);
      if (l < 1) begin
         return s * np * m;
      end
      return s * np * calc_mp(m, l) / l;
   endfunction

   // Total frame width across all lanes.
   function automatic int calc_out_width(input int s, input int np, input int m, input int l);
      return s * np * calc_mp(m, l);
   endfunction

endpackage

// File: rtl/jesd204b_tpl_sample_pack.sv
// Packs one converter sample into a transmitted word: {sample, control, tail}, MSB first.
module jesd204b_tpl_sample_pack #(
   parameter int RESOLUTION  = 11,
   parameter int CONTROL     = 2,
   parameter int SAMPLE_SIZE = 16
) (
   input  logic [RESOLUTION-1:0]  sample,
   output logic [SAMPLE_SIZE-1:0] word
);

   localparam int CTRL_LSB = SAMPLE_SIZE - RESOLUTION - CONTROL;

   // Sample in the top bits; control and tail bits are tied low.
   always_comb begin
      word = '0;
      word[SAMPLE_SIZE-1 -: RESOLUTION] = sample;
      // There is no control input, so the control field is always zero.
      for (int i = 0; i < CONTROL; i++) begin
         word[CTRL_LSB + i] = 1'b0;
      end
   end

endmodule

// File: rtl/jesd204b_tpl.sv
// JESD204B transmit transport layer: maps converter samples onto lanes, one registered frame
// per cycle.
module jesd204b_tpl
   import jesd204b_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int CONVERTERS  = 8,
   parameter int RESOLUTION  = 11,
   parameter int CONTROL     = 2,
   parameter int SAMPLE_SIZE = 16,
   parameter int SAMPLES     = 1
) (
   input  logic                                                    clk,
   input  logic                                                    rst,
   input  logic [SAMPLES*CONVERTERS*RESOLUTION-1:0]                tx_datain,
   output logic [calc_out_width(SAMPLES, SAMPLE_SIZE, CONVERTERS, LANES)-1:0] tx_dataout
);

   localparam int MP    = calc_mp(CONVERTERS, LANES);
   localparam int OUT_W = calc_out_width(SAMPLES, SAMPLE_SIZE, CONVERTERS, LANES);

   if (RESOLUTION + CONTROL > SAMPLE_SIZE || LANES < 1 || CONVERTERS < 1 || SAMPLES < 1
       || CONTROL < 0) begin : g_bad_params
      $error("jesd204b_tpl: illegal parameter set");
   end

   logic [OUT_W-1:0] frame;

   // Word (c*S+s) lands at bit (c*S+s)*N'; lane l is then a contiguous slice of converters.
   for (genvar c = 0; c < MP; c++) begin : g_conv
      for (genvar s = 0; s < SAMPLES; s++) begin : g_smp
         logic [RESOLUTION-1:0] sample;

         if (c < CONVERTERS) begin : g_real
            assign sample = tx_datain[(c*SAMPLES+s)*RESOLUTION +: RESOLUTION];
         end else begin : g_dummy
            // Padding converters carry all-zero words.
            assign sample = '0;
         end

         jesd204b_tpl_sample_pack #(
            .RESOLUTION  (RESOLUTION),
            .CONTROL     (CONTROL),
            .SAMPLE_SIZE (SAMPLE_SIZE)
         ) u_pack (
            .sample (sample),
            .word   (frame[(c*SAMPLES+s)*SAMPLE_SIZE +: SAMPLE_SIZE])
         );
      end
   end

   // Output register: the only state in the block, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_dataout <= '0;
      end else begin
         tx_dataout <= frame;
      end
   end

endmodule

// File: tb/tb_jesd204b_tpl.sv
// Directed bench for jesd204b_tpl: default, padded (M=6) and two-sample (S=2) configurations.
module tb_jesd204b_tpl;

   logic clk;
   logic rst;

   logic [87:0]  din_a;
   logic [127:0] dout_a;
   logic [65:0]  din_p;
   logic [127:0] dout_p;
   logic [87:0]  din_s;
   logic [127:0] dout_s;

   int n_vec;
   int n_bad;

   jesd204b_tpl u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .tx_datain  (din_a),
      .tx_dataout (dout_a)
   );

   jesd204b_tpl #(
      .LANES      (4),
      .CONVERTERS (6)
   ) u_dut_p (
      .clk        (clk),
      .rst        (rst),
      .tx_datain  (din_p),
      .tx_dataout (dout_p)
   );

   jesd204b_tpl #(
      .LANES      (4),
      .CONVERTERS (4),
      .SAMPLES    (2)
   ) u_dut_s (
      .clk        (clk),
      .rst        (rst),
      .tx_datain  (din_s),
      .tx_dataout (dout_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference mapping for the default configuration.
   function automatic logic [127:0] ref_map(input logic [87:0] din);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 8; c++) begin
         r[c*16 +: 16] = {din[c*11 +: 11], 5'b00000};
      end
      return r;
   endfunction

   initial begin
      logic [127:0] exp;
      logic [87:0]  rnd;
      n_vec = 0;
      n_bad = 0;
      rst   = 1'b1;
      din_a = '0;
      din_p = '0;
      din_s = '0;

      #2;
      check("reset_a", dout_a, 128'h0);
      check("reset_p", dout_p, 128'h0);
      tick();
      check("reset_hold", dout_a, 128'h0);

      // First frame after release is the one sampled on the first clean edge.
      din_a = {11'h61b, 11'h71b, 11'h69b, 11'h65b, 11'h63b, 11'h73b, 11'h6bb, 11'h67b};
      #2;
      rst = 1'b0;
      check("no_comb_path", dout_a, 128'h0);
      tick();
      check("lane0", {96'h0, dout_a[31:0]},   128'hD760CF60);
      check("lane1", {96'h0, dout_a[63:32]},  128'hC760E760);
      check("lane2", {96'h0, dout_a[95:64]},  128'hD360CB60);
      check("lane3", {96'h0, dout_a[127:96]}, 128'hC360E360);

      // Mid-stream asynchronous reset between edges.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_clear", dout_a, 128'h0);
      tick();
      check("rst_hold", dout_a, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_pre_edge", dout_a, 128'h0);
      tick();
      check("resume", dout_a, 128'hC360E360D360CB60C760E760D760CF60);

      // Padding: M=6 over L=4 leaves two zero dummy words.
      din_p = {6{11'h7FF}};
      // S=2: converter c sample s carries value 2c+s.
      for (int c = 0; c < 4; c++) begin
         for (int s = 0; s < 2; s++) begin
            din_s[(c*2+s)*11 +: 11] = 11'(c*2 + s);
         end
      end
      tick();
      check("pad", dout_p, 128'h00000000FFE0FFE0FFE0FFE0FFE0FFE0);
      check("s2_lane0", {96'h0, dout_s[31:0]},   128'h00200000);
      check("s2_lane1", {96'h0, dout_s[63:32]},  128'h00600040);
      check("s2_lane2", {96'h0, dout_s[95:64]},  128'h00A00080);
      check("s2_lane3", {96'h0, dout_s[127:96]}, 128'h00E000C0);

      // Walking one: single output bit, past the control and tail field.
      for (int i = 0; i < 88; i++) begin
         din_a = 88'h0;
         din_a[i] = 1'b1;
         tick();
         exp = 128'h0;
         exp[(i / 11) * 16 + (i % 11) + 5] = 1'b1;
         check($sformatf("walk%0d", i), dout_a, exp);
      end

      // Random stream, one-cycle latency.
      for (int k = 0; k < 1000; k++) begin
         rnd = {$urandom(), $urandom(), $urandom()};
         din_a = rnd;
         tick();
         check("random", dout_a, ref_map(rnd));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/jesd204b_tpl.md
JESD204B_TPL -- requirements
Module: jesd204b_tpl

Interface
REQ-001 SHALL have parameter LANES, default 4: number of JESD204B lanes (L).
REQ-002 SHALL have parameter CONVERTERS, default 8: number of converters (M).
REQ-003 SHALL have parameter RESOLUTION, default 11: converter resolution (N).
REQ-004 SHALL have parameter CONTROL, default 2: control bits per sample (CS).
REQ-005 SHALL have parameter SAMPLE_SIZE, default 16: bits per transmitted sample word (N').
REQ-006 SHALL have parameter SAMPLES, default 1: samples per converter per frame (S).
REQ-007 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port tx_datain, input, S*M*N bits: converter samples, converter c sample s at bits [(c*S+s)*N +: N].
REQ-010 SHALL have port tx_dataout, output, S*N'*MP bits: lane-mapped frame, where MP = M rounded up to a multiple of L (MP = M + (L - M%L) when M%L != 0, else M).

Function
REQ-011 SHALL build each sample word, MSB first, as {sample[N-1:0], CS control bits, N'-N-CS tail bits}.
REQ-012 SHALL drive all control bits to 0, because the block has no control input.
REQ-013 SHALL drive all tail bits to 0.
REQ-014 SHALL place the word for converter c, sample s at tx_dataout[(c*S+s)*N' +: N'].
REQ-015 SHALL therefore make lane l = tx_dataout[l*W +: W], with W = S*N'*MP/L, carrying converters l*MP/L .. (l+1)*MP/L-1, the lowest-index converter in the LSBs.
REQ-016 SHALL drive the dummy converters M..MP-1 as all-zero words.
REQ-017 SHALL register tx_dataout: the word captured from tx_datain at rising edge k appears after edge k, giving 1-cycle latency with no combinational input-to-output path.
REQ-018 SHALL use no handshake: every cycle is a valid frame.
REQ-019 SHALL reject at elaboration any parameter set violating N+CS <= N', L >= 1, M >= 1, S >= 1, or CS >= 0.
REQ-020 SHALL contain no state other than the output register.
REQ-021 SHALL make an X/unknown on tx_datain propagate only to the corresponding N bits of the output.

Reset
REQ-022 SHALL clear tx_dataout to all zeros immediately on rst assertion, independent of clk.
REQ-023 SHALL hold tx_dataout at zero while rst is high.
REQ-024 SHALL present, after rst deassertion, the first frame from tx_datain as sampled on the first rising edge with rst low.
REQ-025 SHALL clear the output on a mid-stream rst pulse and resume normal mapping at the next clean edge.

Structure
REQ-026 SHALL keep the width helper functions (padded converter count MP, lane width W, output width) in shared package jesd204b_pkg.
REQ-027 SHALL implement per-sample word packing (data, control and tail insertion) in one sub-module, jesd204b_tpl_sample_pack, instantiated S*MP times in a generate loop.
REQ-028 SHALL implement the output register in the top level.

Verification
REQ-029 Default parameters, tx_datain = {11'h61b,11'h71b,11'h69b,11'h65b,11'h63b,11'h73b,11'h6bb,11'h67b} -> one edge later: lane0=32'hD760CF60, lane1=32'hC760E760, lane2=32'hD360CB60, lane3=32'hC360E360.
REQ-030 Assert rst asynchronously between edges with a nonzero output present -> tx_dataout becomes 0 before the next edge and stays 0 until rst is released.
REQ-031 Padding case, M=6, L=4 (MP=8), all samples 11'h7FF -> words 0..5 = 16'hFFE0 and words 6,7 = 16'h0000.
REQ-032 S=2, M=4, L=4, with converter c sample s = {c,s} in the low bits -> each lane holds its converter's sample0 in bits [15:0] and sample1 in bits [31:16].
REQ-033 Change tx_datain every cycle with a random stream -> tx_dataout equals the reference mapping of the previous cycle's input, for 1000 cycles.
REQ-034 Walking-one across tx_datain -> exactly one output bit is set, at the REQ-014 position shifted by CS+tail, with control and tail bits always 0.
